// File: rtl/param_sort_engine.sv
// param_sort_engine: odd-even transposition sorter for one NUM-element vector.
// A vector is captured in IDLE, sorted in place one phase per clock in SORT,
// and presented in DONE until the consumer takes it.
// Optional build macro SORT_EARLY_EXIT_EN: leaves SORT as soon as one even and
// one odd phase in a row made no swaps (never later than NUM phases).
module param_sort_engine #(
  parameter int DATA_W = 8,
  parameter int NUM    = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM*DATA_W-1:0] in_data,
  input  logic                  descend,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM*DATA_W-1:0] out_data,
  output logic                  busy
);

  localparam int CNT_W = $clog2(NUM + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  phase;
  logic              desc_q;
  logic [DATA_W-1:0] elem     [NUM];
  logic [DATA_W-1:0] elem_nxt [NUM];
  logic              accept;
  logic              last_phase;
  logic              sort_step;

`ifdef SORT_EARLY_EXIT_EN
  logic              any_swap;
  logic              prev_quiet;
  logic              settled;
`endif

  // Unsigned order test for one adjacent pair; equal values never swap.
  function automatic logic need_swap(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b,
                                     input logic              desc);
    return desc ? (a < b) : (a > b);
  endfunction

  assign accept = (state == IDLE) && in_valid;

`ifdef SORT_EARLY_EXIT_EN
  assign last_phase = (phase == CNT_W'(NUM)) || settled;
`else
  assign last_phase = (phase == CNT_W'(NUM));
`endif

  // A phase is applied only while SORT still has work; the exit cycle is idle.
  assign sort_step = (state == SORT) && !last_phase;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = SORT;
      SORT:    if (last_phase) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == SORT);
    out_valid = (state == DONE);
  end

  // One compare-exchange phase: pairs start at index 0 on even phases, 1 on odd.
  always_comb begin
`ifdef SORT_EARLY_EXIT_EN
    any_swap = 1'b0;
`endif
    for (int i = 0; i < NUM; i++) begin
      elem_nxt[i] = elem[i];
    end
    for (int i = 0; i < NUM - 1; i++) begin
      if ((i % 2) == int'(phase[0])) begin
        if (need_swap(elem[i], elem[i+1], desc_q)) begin
          elem_nxt[i]   = elem[i+1];
          elem_nxt[i+1] = elem[i];
`ifdef SORT_EARLY_EXIT_EN
          any_swap      = 1'b1;
`endif
        end
      end
    end
  end

  // Element array: load on accept, update once per sorting phase, hold otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM; i++) begin
        elem[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < NUM; i++) begin
        elem[i] <= in_data[i*DATA_W +: DATA_W];
      end
    end else if (sort_step) begin
      for (int i = 0; i < NUM; i++) begin
        elem[i] <= elem_nxt[i];
      end
    end
  end

  // Phase counter and the sort order latched for the vector in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase  <= '0;
      desc_q <= 1'b0;
    end else if (accept) begin
      phase  <= '0;
      desc_q <= descend;
    end else if (sort_step) begin
      phase  <= phase + CNT_W'(1);
    end
  end

`ifdef SORT_EARLY_EXIT_EN
  // Swap detection: settled after two consecutive swap-free phases.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_quiet <= 1'b0;
      settled    <= 1'b0;
    end else if (accept) begin
      prev_quiet <= 1'b0;
      settled    <= 1'b0;
    end else if (sort_step) begin
      prev_quiet <= !any_swap;
      settled    <= !any_swap && prev_quiet;
    end
  end
`endif

  // Output vector always mirrors the element array.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM; i++) begin
      out_data[i*DATA_W +: DATA_W] = elem[i];
    end
  end

endmodule

// File: tb/tb_param_sort_engine.sv
// Testbench for param_sort_engine: directed and random vectors checked
// against a plain-array sorting model. Honours SORT_EARLY_EXIT_EN if defined.
module tb_param_sort_engine;

  localparam int DATA_W = 8;
  localparam int NUM    = 6;
  localparam int VW     = NUM * DATA_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic          descend;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  param_sort_engine #(.DATA_W(DATA_W), .NUM(NUM)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .descend   (descend),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack(input int v[NUM]);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM; i++) r[i*DATA_W +: DATA_W] = DATA_W'(v[i]);
    return r;
  endfunction

  // Reference result: fully sorted values, ascending or reversed.
  function automatic logic [VW-1:0] model_sort(input logic [VW-1:0] v, input logic desc);
    int a[NUM];
    int t;
    int b[NUM];
    for (int i = 0; i < NUM; i++) a[i] = int'(v[i*DATA_W +: DATA_W]);
    for (int i = 0; i < NUM; i++)
      for (int j = 0; j < NUM - 1 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    for (int i = 0; i < NUM; i++) b[i] = desc ? a[NUM-1-i] : a[i];
    return pack(b);
  endfunction

  // Cycles from the accept edge until out_valid is first seen.
  function automatic int model_latency(input logic [VW-1:0] v, input logic desc);
`ifdef SORT_EARLY_EXIT_EN
    int a[NUM];
    int t;
    bit sw;
    bit prev_sw;
    for (int i = 0; i < NUM; i++) a[i] = int'(v[i*DATA_W +: DATA_W]);
    prev_sw = 1'b1;
    for (int p = 0; p < NUM; p++) begin
      sw = 1'b0;
      for (int j = p % 2; j + 1 < NUM; j += 2) begin
        if (desc ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
          sw = 1'b1;
        end
      end
      if (p >= 1 && !sw && !prev_sw) return p + 2;
      prev_sw = sw;
    end
    return NUM + 1;
`else
    if (desc === 1'bx) return 0;
    return (v === v) ? NUM + 1 : NUM + 1;
`endif
  endfunction

  task automatic run_vec(input logic [VW-1:0] v, input logic desc, input int hold,
                         input string tag);
    logic [VW-1:0] exp;
    logic [VW-1:0] held;
    int            lat;
    int            n;
    int            w;
    bit            seen;
    exp = model_sort(v, desc);
    lat = model_latency(v, desc);
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, " in_ready_idle"}, 64'(in_ready), 64'(1));
    out_ready = (hold == 0);
    in_data   = v;
    descend   = desc;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    descend  = ~desc;
    for (int i = 0; i < NUM; i++) in_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    check({tag, " busy_sort"}, 64'(busy), 64'(1));
    check({tag, " in_ready_sort"}, 64'(in_ready), 64'(0));
    n = 1;
    seen = 1'b0;
    while (n <= 4 * NUM && !seen) begin
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
      else n++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, seen ? 64'(n) : 64'hFFFF, 64'(lat));
    check({tag, " data"}, 64'(out_data), 64'(exp));
    check({tag, " busy_done"}, 64'(busy), 64'(0));
    check({tag, " in_ready_done"}, 64'(in_ready), 64'(0));
    held = out_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, " hold_valid"}, 64'(out_valid), 64'(1));
      check({tag, " hold_data"}, 64'(out_data), 64'(held));
      check({tag, " hold_in_ready"}, 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " valid_drop"}, 64'(out_valid), 64'(0));
    check({tag, " in_ready_back"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    int            d[NUM];
    logic [VW-1:0] v;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    descend   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 64'(out_valid), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst in_ready", 64'(in_ready), 64'(1));
    check("rst out_data", 64'(out_data), 64'(0));
    reset = 1'b1;

    d = '{5, 3, 8, 1, 9, 2};
    run_vec(pack(d), 1'b0, 0, "asc");
    run_vec(pack(d), 1'b1, 0, "desc");
    d = '{7, 7, 0, 255, 0, 7};
    run_vec(pack(d), 1'b0, 0, "unsigned");
    d = '{4, 9, 1, 1, 200, 3};
    run_vec(pack(d), 1'b0, 4, "backpressure");
    d = '{1, 2, 3, 4, 5, 6};
    run_vec(pack(d), 1'b0, 0, "presorted");

    // Abort a vector mid-sort with reset, then sort a fresh one.
    d = '{9, 8, 7, 6, 5, 4};
    in_data  = pack(d);
    descend  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("abort out_valid", 64'(out_valid), 64'(0));
    check("abort busy", 64'(busy), 64'(0));
    check("abort in_ready", 64'(in_ready), 64'(1));
    check("abort out_data", 64'(out_data), 64'(0));
    d = '{6, 5, 4, 3, 2, 1};
    run_vec(pack(d), 1'b0, 0, "after_abort");

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NUM; i++)
        v[i*DATA_W +: DATA_W] = (r % 3 == 0) ? DATA_W'($urandom_range(0, 3))
                                             : DATA_W'($urandom);
      run_vec(v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_sort_engine.md
PARAM_SORT_ENGINE -- requirements
Module: param_sort_engine

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, bit width of each unsigned element.
REQ-002 SHALL provide parameter NUM, default 6, element count per vector; legal range 2..32.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-low reset: low at a rising clk edge resets the block.
REQ-005 SHALL provide port in_valid  input  1  in_data and descend are valid.
REQ-006 SHALL provide port in_ready  output  1  block can accept a vector.
REQ-007 SHALL provide port in_data  input  NUM*DATA_W  packed vector; element i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL provide port descend  input  1  sort order: 0 ascending, 1 descending; sampled on accept.
REQ-009 SHALL provide port out_valid  output  1  out_data holds a sorted vector.
REQ-010 SHALL provide port out_ready  input  1  consumer takes out_data.
REQ-011 SHALL provide port out_data  output  NUM*DATA_W  sorted vector, same packing as in_data.
REQ-012 SHALL provide port busy  output  1  high in SORT state.

Function
REQ-013 SHALL implement FSM states IDLE, SORT, DONE.
REQ-014 IDLE: in_ready=1; on in_valid&&in_ready, capture in_data into the element register array, latch descend, clear phase counter, go to SORT.
REQ-015 SORT: one phase per cycle; even phase (counter even) compare-exchanges pairs (0,1),(2,3)...; odd phase compares pairs (1,2),(3,4)...; unpaired end element unchanged.
REQ-016 Ascending: swap when elem[i] > elem[i+1]; descending: swap when elem[i] < elem[i+1]; equal values SHALL NOT swap.
REQ-017 Comparison SHALL be unsigned over DATA_W bits; no width growth.
REQ-018 Phase counter width SHALL be $clog2(NUM+1); SORT exits to DONE after exactly NUM phases (macro absent).
REQ-019 Latency: accept at edge k -> out_valid high after edge k+NUM+1 (NUM phases, one transition to DONE).
REQ-020 DONE: out_valid=1; out_data SHALL remain stable while out_valid&&!out_ready.
REQ-021 DONE with out_ready=1 at an edge -> IDLE; in_ready rises the following cycle (no same-cycle accept in DONE).
REQ-022 in_ready SHALL be 0 in SORT and DONE; in_valid there is ignored.
REQ-023 in_valid and descend changes outside the accept cycle SHALL NOT affect the vector in flight.
REQ-024 out_data SHALL reflect the element register array in all states; contents are meaningful only when out_valid=1.

Reset
REQ-025 On reset low: state=IDLE, out_valid=0, busy=0, in_ready=1 after the edge, phase counter=0, element array=0, latched descend=0.
REQ-026 Reset low in SORT or DONE SHALL abort the vector; no out_valid pulse for it.
REQ-027 Reset SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-028 Macro SORT_EARLY_EXIT_EN, when defined, SHALL add a swap-detect flag: after two consecutive phases (one even, one odd) with zero swaps, SORT exits to DONE immediately, minimum 2 phases.
REQ-029 With SORT_EARLY_EXIT_EN defined, exit SHALL still occur no later than NUM phases.
REQ-030 Without SORT_EARLY_EXIT_EN, phase count SHALL be exactly NUM for every vector and no swap-detect logic is present.

Verification (NUM=6, DATA_W=8, elements listed 0..5)
REQ-031 Accept [5,3,8,1,9,2], descend=0, out_ready=1 -> out_data [1,2,3,5,8,9], out_valid 7 cycles after accept edge, for one cycle.
REQ-032 Same input, descend=1 -> [9,8,5,3,2,1].
REQ-033 Input [7,7,0,255,0,7], descend=0 -> [0,0,7,7,7,255]; 255 treated as largest (unsigned).
REQ-034 out_ready held 0 for 4 cycles in DONE -> out_valid and out_data unchanged, in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-035 reset low during phase 3 -> next cycle out_valid=0, busy=0, in_ready=1; a new vector [6,5,4,3,2,1] sorts to [1,2,3,4,5,6].
REQ-036 Pre-sorted [1,2,3,4,5,6]: with SORT_EARLY_EXIT_EN -> out_valid 3 cycles after accept; without -> 7 cycles.
